// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a show-ahead byte FIFO and valid/ready drain.
//   clk_i, rst_ni          : system clock, synchronous active-low reset
//   ps2_clk_i, ps2_data_i  : raw asynchronous PS/2 lines
//   data_o, valid_o, ready_i, count_o : FIFO head, not-empty, consumer pop, occupancy
//   parity_err_o, frame_err_o, timeout_err_o, overflow_o : single-cycle error pulses
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          timeout_err_o,
    output logic                          overflow_o
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLM1 = FILTER_LEN - 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;
    logic          clk_s1, clk_s2, dat_s1, dat_s2, clk_f, clk_f_d;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fall, timeout, eval, good, full, pop, push;
    assign fall    = clk_f_d & ~clk_f;
    // Timeout wins over a coincident fall, so the frame is aborted rather than advanced.
    assign timeout = (state != IDLE) && (tmo_cnt == TIMEOUT_CYCLES[TW-1:0]);
    assign eval    = fall && !timeout && (state == STOP);
    assign good    = eval && dat_s2 && (^shreg ^ par);
    assign full    = count == FIFO_DEPTH[AW:0];
    assign pop     = valid_o && ready_i;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign push    = good && (!full || pop);
    assign valid_o = count != '0;
    assign count_o = count;
    assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clk_s1        <= 1'b1;
            clk_s2        <= 1'b1;
            dat_s1        <= 1'b1;
            dat_s2        <= 1'b1;
            clk_f         <= 1'b1;
            clk_f_d       <= 1'b1;
            flt_cnt       <= '0;
            tmo_cnt       <= '0;
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            par           <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            timeout_err_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk_i;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data_i;
            dat_s2  <= dat_s1;
            clk_f_d <= clk_f;
            // clk_f follows only after FILTER_LEN consecutive disagreeing cycles.
            if (clk_s2 == clk_f) flt_cnt <= '0;
            else if (flt_cnt == FLM1[FW-1:0]) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else flt_cnt <= flt_cnt + 1'b1;
            tmo_cnt       <= (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;
            frame_err_o   <= eval && !dat_s2;
            parity_err_o  <= eval && dat_s2 && !(^shreg ^ par);
            timeout_err_o <= timeout;
            overflow_o    <= good && full && !pop;
            if (timeout) state <= IDLE;
            else if (fall) begin
                case (state)
                    IDLE: if (!dat_s2) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) mem[wr_ptr] <= shreg;
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo with default parameters.
module tb_ps2_rx_fifo;
    localparam int FL = 8;
    localparam int TO = 5000;
    logic       clk_i = 1'b0, rst_ni = 1'b0, ps2_clk_i = 1'b1, ps2_data_i = 1'b1, ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [4:0] count_o;
    logic       parity_err_o, frame_err_o, timeout_err_o, overflow_o;
    int checks = 0, errors = 0;
    int perr_n = 0, ferr_n = 0, tmo_n = 0, ovf_n = 0;
    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
        .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .timeout_err_o(timeout_err_o), .overflow_o(overflow_o)
    );
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) begin
        if (parity_err_o) perr_n <= perr_n + 1;
        if (frame_err_o) ferr_n <= ferr_n + 1;
        if (timeout_err_o) tmo_n <= tmo_n + 1;
        if (overflow_o) ovf_n <= ovf_n + 1;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    // One PS/2 bit: data settles while clock is high, then a 20-cycle low phase.
    // pop raises ready_i for exactly the cycle in which the fall strobe is evaluated.
    task automatic send_bit(input logic b, input logic glitch, input logic pop);
        @(negedge clk_i);
        ps2_data_i = b;
        repeat (12) @(negedge clk_i);
        if (glitch) begin
            ps2_clk_i = 1'b0;
            repeat (FL - 1) @(negedge clk_i);
            ps2_clk_i = 1'b1;
            repeat (12) @(negedge clk_i);
        end
        ps2_clk_i = 1'b0;
        if (pop) begin
            repeat (FL + 2) @(negedge clk_i);
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
            repeat (9) @(negedge clk_i);
        end else repeat (20) @(negedge clk_i);
        ps2_clk_i = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input logic glitch, input logic pop);
        logic [10:0] f;
        f = {stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i], glitch, pop && (i == 10));
        repeat (4) @(negedge clk_i);
    endtask
    task automatic pop_one();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask
    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_data", data_o, 0);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        send_frame(8'h1C, 0, 1, 0, 0);
        check("t1_valid", valid_o, 1);
        check("t1_data", data_o, 8'h1C);
        check("t1_count", count_o, 1);
        pop_one();
        check("t1_pop_valid", valid_o, 0);
        check("t1_pop_count", count_o, 0);
        send_frame(8'h5A, 1, 1, 0, 0);
        check("t2_perr", perr_n, 1);
        check("t2_count", count_o, 0);
        send_frame(8'hF0, 0, 1, 0, 0);
        check("t2_data", data_o, 8'hF0);
        check("t2_count2", count_o, 1);
        pop_one();
        send_frame(8'h3C, 0, 1, 1, 0);
        check("t3_glitch_data", data_o, 8'h3C);
        check("t3_glitch_count", count_o, 1);
        pop_one();
        send_frame(8'h12, 0, 0, 0, 0);
        check("t3_ferr", ferr_n, 1);
        check("t3_perr_only_once", perr_n, 1);
        check("t3_count", count_o, 0);
        send_bit(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 0, 0);
        repeat (TO + FL + 4) @(negedge clk_i);
        check("t4_tmo", tmo_n, 1);
        check("t4_count", count_o, 0);
        check("t4_ferr", ferr_n, 1);
        send_frame(8'h29, 0, 1, 0, 0);
        check("t4_data", data_o, 8'h29);
        check("t4_count2", count_o, 1);
        check("t4_tmo2", tmo_n, 1);
        pop_one();
        for (int i = 0; i < 17; i++) begin
            send_frame(i[7:0], 0, 1, 0, 0);
            if (i == 15) check("t5_full", count_o, 16);
        end
        check("t5_ovf", ovf_n, 1);
        check("t5_count", count_o, 16);
        @(negedge clk_i);
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t5_drain", data_o, i);
            @(negedge clk_i);
        end
        ready_i = 1'b0;
        check("t5_empty", count_o, 0);
        for (int i = 0; i < 16; i++) send_frame(i[7:0], 0, 1, 0, 0);
        check("t5_refill", count_o, 16);
        send_frame(8'h10, 0, 1, 0, 1);
        check("t5_pop_ovf", ovf_n, 1);
        check("t5_pop_count", count_o, 16);
        @(negedge clk_i);
        ready_i = 1'b1;
        for (int i = 1; i < 17; i++) begin
            check("t5_drain2", data_o, i);
            @(negedge clk_i);
        end
        ready_i = 1'b0;
        check("t5_empty2", count_o, 0);
        send_frame(8'hA1, 0, 1, 0, 0);
        send_frame(8'hB2, 0, 1, 0, 0);
        send_frame(8'hC3, 0, 1, 0, 0);
        check("t6_count3", count_o, 3);
        send_bit(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("t6_valid", valid_o, 0);
        check("t6_count", count_o, 0);
        repeat (20) @(negedge clk_i);
        send_frame(8'h6B, 0, 1, 0, 0);
        check("t6_data", data_o, 8'h6B);
        check("t6_count2", count_o, 1);
        check("t6_tmo", tmo_n, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
